// File: rtl/organ_pkg.sv
// organ_pkg: shared types and constants for the organ keypad scanner
package organ_pkg;
  localparam int KEY_W = 4;
  localparam logic [3:0] ROW_RESET = 4'b1110;
  typedef logic [1:0] state_t;
  localparam state_t ST_SCAN     = 2'd0;
  localparam state_t ST_DEBOUNCE = 2'd1;
  localparam state_t ST_HOLD     = 2'd2;
  function automatic logic [1:0] low_index(input logic [3:0] v_n);
    return !v_n[0] ? 2'd0 : !v_n[1] ? 2'd1 : !v_n[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/key_scan_debounce_if.sv
// key_scan_debounce_if: keypad matrix lines plus the key-event outputs for tone select
interface key_scan_debounce_if;
  import organ_pkg::*;
  logic [3:0]       col_n;
  logic [3:0]       row_n;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_press;
  logic             key_release;
  modport master (input col_n, output row_n, key_code, key_valid, key_press, key_release);
  modport slave  (output col_n, input row_n, key_code, key_valid, key_press, key_release);
endinterface

// File: rtl/key_scan_debounce_tick_sync_edge.sv
// tick_sync_edge: synchronise the 1 kHz square wave and emit a one-clock tick on its rising edge
module tick_sync_edge (
  input  logic I_CLK,
  input  logic rst_n,
  input  logic i_clk_1k,
  output logic o_tick
);
  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_tick;
  // two-stage synchroniser, then a registered rising-edge detect
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_clk_1k};
      r_prev <= r_sync[1];
      r_tick <= r_sync[1] & ~r_prev;
    end
  end
  assign o_tick = r_tick;
endmodule

// File: rtl/key_scan_debounce.sv
// key_scan_debounce: 4x4 keypad scan with debounce; define KEY_REPEAT_EN for auto-repeat
module key_scan_debounce
  import organ_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                 I_CLK,
  input  logic                 rst_n,
  input  logic                 clk_1k,
  key_scan_debounce_if.master  kp
);
  logic             w_tick;
  logic             w_cap_low;
  logic             w_cnt_hit;
  logic             w_rep_press;
  logic [7:0]       w_cnt_inc;
  logic [3:0]       w_row_next;
  state_t           r_state;
  logic [3:0]       r_row_n;
  logic [1:0]       r_row_cap;
  logic [1:0]       r_col_cap;
  logic [7:0]       r_cnt;
  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_key_press;
  logic             r_key_release;

  tick_sync_edge u_tick (
    .I_CLK    (I_CLK),
    .rst_n    (rst_n),
    .i_clk_1k (clk_1k),
    .o_tick   (w_tick)
  );

  assign w_cap_low  = ~kp.col_n[r_col_cap];
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_cnt_hit  = w_cnt_inc == 8'(DEBOUNCE_MS - 1);
  assign w_row_next = {r_row_n[2:0], r_row_n[3]};

`ifdef KEY_REPEAT_EN
  logic [15:0] r_rep;
  logic [15:0] w_rep_inc;
  logic        w_rep_wrap;
  assign w_rep_inc   = r_rep + 16'd1;
  assign w_rep_wrap  = w_rep_inc == 16'(REPEAT_DELAY_MS + REPEAT_RATE_MS);
  assign w_rep_press = w_tick && r_state == ST_HOLD && w_cap_low &&
                       (w_rep_inc == 16'(REPEAT_DELAY_MS) || w_rep_wrap);
  // hold-time counter: counts held ticks, folds back to the delay point after each rate period
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n)
      r_rep <= '0;
    else if (w_tick)
      r_rep <= (r_state != ST_HOLD || (!w_cap_low && w_cnt_hit)) ? 16'd0 :
               !w_cap_low ? r_rep :
               w_rep_wrap ? 16'(REPEAT_DELAY_MS) : w_rep_inc;
  end
`else
  localparam int unused_rep = REPEAT_DELAY_MS + REPEAT_RATE_MS;
  assign w_rep_press = 1'b0;
`endif

  // scan/debounce/hold sequencer; strobes self-clear on the following clock
  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_SCAN;
      r_row_n       <= ROW_RESET;
      r_row_cap     <= '0;
      r_col_cap     <= '0;
      r_cnt         <= '0;
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_key_press   <= w_rep_press;
      r_key_release <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (&kp.col_n) begin
              r_row_n <= w_row_next;
            end else begin
              r_row_cap <= low_index(r_row_n);
              r_col_cap <= low_index(kp.col_n);
              r_cnt     <= '0;
              r_state   <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (!w_cap_low) begin
              r_row_n <= w_row_next;
              r_state <= ST_SCAN;
            end else if (w_cnt_hit) begin
              r_key_code  <= {r_row_cap, r_col_cap};
              r_key_valid <= 1'b1;
              r_key_press <= 1'b1;
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_HOLD: begin
            if (w_cap_low) begin
              r_cnt <= '0;
            end else if (w_cnt_hit) begin
              r_key_valid   <= 1'b0;
              r_key_release <= 1'b1;
              r_cnt         <= '0;
              r_row_n       <= w_row_next;
              r_state       <= ST_SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  assign kp.row_n       = r_row_n;
  assign kp.key_code    = r_key_code;
  assign kp.key_valid   = r_key_valid;
  assign kp.key_press   = r_key_press;
  assign kp.key_release = r_key_release;
endmodule

// File: tb/tb_key_scan_debounce.sv
// tb_key_scan_debounce: directed bench with a keypad matrix model and pulse counters
module tb_key_scan_debounce;
  logic        I_CLK;
  logic        rst_n;
  logic        clk_1k;
  logic [15:0] pressed;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_press  = 0;
  int          n_release = 0;
  int          n_both   = 0;
  int          p0;
  int          r0;
  logic [3:0]  exp_row;

  key_scan_debounce_if kif ();

  key_scan_debounce dut (
    .I_CLK  (I_CLK),
    .rst_n  (rst_n),
    .clk_1k (clk_1k),
    .kp     (kif)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  always_comb begin
    kif.col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.row_n[r]) kif.col_n[c] = 1'b0;
  end

  always @(posedge I_CLK) begin
    if (kif.key_press) n_press <= n_press + 1;
    if (kif.key_release) n_release <= n_release + 1;
    if (kif.key_press && kif.key_release) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    clk_1k = 1'b1;
    repeat (8) @(posedge I_CLK);
    #1;
    clk_1k = 1'b0;
    repeat (8) @(posedge I_CLK);
    #1;
  endtask

  task automatic wait_row0();
    for (int k = 0; k < 4 && kif.row_n !== 4'b1110; k++) do_tick();
    check("row0_sync", 32'(kif.row_n), 32'hE);
  endtask

  initial begin
    rst_n   = 1'b0;
    clk_1k  = 1'b0;
    pressed = '0;
    repeat (3) @(posedge I_CLK);
    #1;
    check("rst_row_n", 32'(kif.row_n), 32'hE);
    check("rst_key_code", 32'(kif.key_code), 0);
    check("rst_key_valid", 32'(kif.key_valid), 0);
    check("rst_key_press", 32'(kif.key_press), 0);
    check("rst_key_release", 32'(kif.key_release), 0);
    rst_n = 1'b1;

    exp_row = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      check("idle_row", 32'(kif.row_n), 32'(exp_row));
      do_tick();
      exp_row = {exp_row[2:0], exp_row[3]};
    end
    check("idle_press", n_press, 0);
    check("idle_release", n_release, 0);

    p0 = n_press;
    pressed[9] = 1'b1;
    repeat (21) do_tick();
    check("clean_early", n_press - p0, 0);
    check("clean_early_valid", 32'(kif.key_valid), 0);
    do_tick();
    check("clean_press", n_press - p0, 1);
    check("clean_code", 32'(kif.key_code), 9);
    check("clean_valid", 32'(kif.key_valid), 1);
    check("clean_row_frozen", 32'(kif.row_n), 32'hB);
    repeat (5) do_tick();
    check("clean_once", n_press - p0, 1);
    r0 = n_release;
    pressed = '0;
    repeat (18) do_tick();
    check("rel_early_valid", 32'(kif.key_valid), 1);
    check("rel_early", n_release - r0, 0);
    repeat (2) do_tick();
    check("rel_pulse", n_release - r0, 1);
    check("rel_valid", 32'(kif.key_valid), 0);
    check("rel_code_kept", 32'(kif.key_code), 9);

    wait_row0();
    p0 = n_press;
    pressed[2] = 1'b1;
    repeat (5) do_tick();
    pressed[2] = 1'b0;
    do_tick();
    check("bounce_abandon", n_press - p0, 0);
    check("bounce_row_adv", 32'(kif.row_n), 32'hD);
    check("bounce_valid", 32'(kif.key_valid), 0);
    pressed[2] = 1'b1;
    repeat (22) do_tick();
    check("bounce_early", n_press - p0, 0);
    do_tick();
    check("bounce_press", n_press - p0, 1);
    check("bounce_code", 32'(kif.key_code), 2);
    pressed = '0;
    repeat (20) do_tick();
    check("bounce_rel_valid", 32'(kif.key_valid), 0);

    wait_row0();
    p0 = n_press;
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    repeat (20) do_tick();
    check("multi_press", n_press - p0, 1);
    check("multi_code", 32'(kif.key_code), 0);
    check("multi_valid", 32'(kif.key_valid), 1);
    pressed = '0;
    repeat (20) do_tick();

    wait_row0();
    pressed[9] = 1'b1;
    repeat (22) do_tick();
    check("pre_rst_valid", 32'(kif.key_valid), 1);
    check("pre_rst_code", 32'(kif.key_code), 9);
    r0 = n_release;
    @(posedge I_CLK);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_row_n", 32'(kif.row_n), 32'hE);
    check("arst_code", 32'(kif.key_code), 0);
    check("arst_valid", 32'(kif.key_valid), 0);
    check("arst_release", 32'(kif.key_release), 0);
    repeat (20) @(posedge I_CLK);
    #1;
    pressed = '0;
    check("arst_no_release", n_release - r0, 0);
    rst_n = 1'b1;

`ifdef KEY_REPEAT_EN
    p0 = n_press;
    pressed[3] = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      do_tick();
      if (i == 19 || i == 20 || i == 519 || i == 520 || i == 619 || i == 620 ||
          i == 719 || i == 720 || i == 800)
        check("repeat_count", n_press - p0,
              int'(i >= 20) + int'(i >= 520) + int'(i >= 620) + int'(i >= 720));
    end
    pressed = '0;
    repeat (20) do_tick();
`endif

    check("no_overlap", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
